// File: rtl/reg_rename_table_pkg.sv
// Shared types and constants for the register rename table.
package reg_rename_table_pkg;

    typedef enum logic [1:0] {
        SRC_GPR    = 2'd0,
        SRC_IMM    = 2'd1,
        SRC_PC     = 2'd2,
        SRC_UNUSED = 2'd3
    } reg_status_t;

    typedef logic [3:0] nzcv_t;

    localparam int RRT_GPR_COUNT = 32;
    localparam int RRT_DATA_W    = 64;
    localparam int RRT_ROB_IDX_W = 4;
    localparam int RRT_XZR_IDX   = RRT_GPR_COUNT - 1;

    typedef struct packed {
        logic [RRT_DATA_W-1:0]    val;
        logic                     vld;
        logic [RRT_ROB_IDX_W-1:0] tag;
    } rrt_src_t;

endpackage

// File: rtl/reg_rename_table_read_port.sv
// One source operand read: status mux, zero register, optional commit bypass
// (enabled by RRT_COMMIT_BYPASS_EN).
module rrt_read_port
    import reg_rename_table_pkg::*;
#(
    parameter int DATA_W    = RRT_DATA_W,
    parameter int ROB_IDX_W = RRT_ROB_IDX_W
) (
    input  reg_status_t          status,
    input  logic                 is_xzr,
    input  logic [DATA_W-1:0]    rd_val,
    input  logic                 rd_busy,
    input  logic [ROB_IDX_W-1:0] rd_tag,
    input  logic [DATA_W-1:0]    imm,
    input  logic [DATA_W-1:0]    pc,
    input  logic                 cmt_hit,
    input  logic [DATA_W-1:0]    cmt_val,
    output logic [DATA_W-1:0]    val,
    output logic                 vld,
    output logic [ROB_IDX_W-1:0] tag
);

`ifndef RRT_COMMIT_BYPASS_EN
    logic unused_cmt_s;
    assign unused_cmt_s = ^{cmt_hit, cmt_val};
`endif

    // Operand select; non-GPR sources are always ready and carry tag 0
    always_comb begin
        val = '0;
        vld = 1'b1;
        tag = '0;
        case (status)
            SRC_GPR: begin
                if (is_xzr) begin
                    val = '0;
                end else begin
`ifdef RRT_COMMIT_BYPASS_EN
                    if (cmt_hit) begin
                        val = cmt_val;
                        vld = 1'b1;
                    end else begin
                        val = rd_val;
                        vld = ~rd_busy;
                    end
`else
                    val = rd_val;
                    vld = ~rd_busy;
`endif
                    tag = rd_tag;
                end
            end
            SRC_IMM:    val = imm;
            SRC_PC:     val = pc;
            SRC_UNUSED: val = '0;
            default:    val = '0;
        endcase
    end

endmodule

// File: rtl/reg_rename_table.sv
// Architectural GPR/NZCV store with rename tags between decode and ROB.
// Optional same-cycle commit bypass: define RRT_COMMIT_BYPASS_EN.
module reg_rename_table
    import reg_rename_table_pkg::*;
#(
    parameter int GPR_COUNT = RRT_GPR_COUNT,
    parameter int DATA_W    = RRT_DATA_W,
    parameter int ROB_IDX_W = RRT_ROB_IDX_W,
    parameter int N_SRC     = 2,
    parameter int IMM_W     = 64,
    localparam int IDX_W    = $clog2(GPR_COUNT)
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_d_valid,
    output logic                       out_d_ready,
    input  logic [N_SRC*IDX_W-1:0]     in_d_src,
    input  logic [N_SRC*2-1:0]         in_d_src_status,
    input  logic [IMM_W-1:0]           in_d_imm,
    input  logic [DATA_W-1:0]          in_d_pc,
    input  logic [IDX_W-1:0]           in_d_dst,
    input  logic                       in_d_dst_en,
    input  logic                       in_d_set_nzcv,
    input  logic                       in_d_uses_nzcv,
    input  logic [ROB_IDX_W-1:0]       in_rob_next_idx,
    output logic                       out_rob_valid,
    input  logic                       in_rob_ready,
    output logic [N_SRC*DATA_W-1:0]    out_rob_src_val,
    output logic [N_SRC-1:0]           out_rob_src_vld,
    output logic [N_SRC*ROB_IDX_W-1:0] out_rob_src_tag,
    output logic [3:0]                 out_rob_nzcv,
    output logic                       out_rob_nzcv_vld,
    output logic [ROB_IDX_W-1:0]       out_rob_nzcv_tag,
    output logic [IDX_W-1:0]           out_rob_dst,
    output logic                       out_rob_dst_en,
    output logic                       out_rob_set_nzcv,
    input  logic                       in_cmt_valid,
    input  logic [IDX_W-1:0]           in_cmt_reg,
    input  logic [ROB_IDX_W-1:0]       in_cmt_tag,
    input  logic [DATA_W-1:0]          in_cmt_val,
    input  logic                       in_cmt_set_nzcv,
    input  logic [3:0]                 in_cmt_nzcv,
    input  logic                       in_flush
);

    localparam int XZR_I = GPR_COUNT - 1;
    localparam logic [IDX_W-1:0] XZR_IDX = IDX_W'(XZR_I);

    logic [DATA_W-1:0]    gpr_val_r [GPR_COUNT];
    logic [ROB_IDX_W-1:0] gpr_tag_r [GPR_COUNT];
    logic [GPR_COUNT-1:0] gpr_busy_r;
    nzcv_t                nzcv_r;
    logic                 nzcv_busy_r;
    logic [ROB_IDX_W-1:0] nzcv_tag_r;

    logic                       rob_valid_r;
    logic [N_SRC*DATA_W-1:0]    rob_src_val_r;
    logic [N_SRC-1:0]           rob_src_vld_r;
    logic [N_SRC*ROB_IDX_W-1:0] rob_src_tag_r;
    nzcv_t                      rob_nzcv_r;
    logic                       rob_nzcv_vld_r;
    logic [ROB_IDX_W-1:0]       rob_nzcv_tag_r;
    logic [IDX_W-1:0]           rob_dst_r;
    logic                       rob_dst_en_r;
    logic                       rob_set_nzcv_r;

    logic                 d_ready_s;
    logic                 accept_s;
    logic                 rename_s;
    logic [DATA_W-1:0]    imm_ext_s;
    logic [N_SRC-1:0]     hit_s;
    logic [DATA_W-1:0]    src_val_s [N_SRC];
    logic [N_SRC-1:0]     src_vld_s;
    logic [ROB_IDX_W-1:0] src_tag_s [N_SRC];
    nzcv_t                nzcv_val_s;
    logic                 nzcv_vld_s;
    logic [ROB_IDX_W-1:0] nzcv_tag_s;

    assign d_ready_s = ~rob_valid_r | in_rob_ready;
    assign accept_s  = in_d_valid & d_ready_s;
    assign rename_s  = accept_s & in_d_dst_en & (in_d_dst != XZR_IDX);
    assign imm_ext_s = DATA_W'(in_d_imm);

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        logic [IDX_W-1:0] idx_s;
        assign idx_s    = in_d_src[g*IDX_W +: IDX_W];
        assign hit_s[g] = in_cmt_valid & (in_cmt_reg == idx_s) & gpr_busy_r[idx_s]
                        & (gpr_tag_r[idx_s] == in_cmt_tag);
        rrt_read_port #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_port (
            .status  (reg_status_t'(in_d_src_status[g*2 +: 2])),
            .is_xzr  (idx_s == XZR_IDX),
            .rd_val  (gpr_val_r[idx_s]),
            .rd_busy (gpr_busy_r[idx_s]),
            .rd_tag  (gpr_tag_r[idx_s]),
            .imm     (imm_ext_s),
            .pc      (in_d_pc),
            .cmt_hit (hit_s[g]),
            .cmt_val (in_cmt_val),
            .val     (src_val_s[g]),
            .vld     (src_vld_s[g]),
            .tag     (src_tag_s[g])
        );
    end

    // Flags operand; a non-consumer gets a ready all-zero operand
    always_comb begin
        nzcv_val_s = 4'b0000;
        nzcv_vld_s = 1'b1;
        nzcv_tag_s = '0;
        if (in_d_uses_nzcv) begin
            nzcv_tag_s = nzcv_tag_r;
`ifdef RRT_COMMIT_BYPASS_EN
            if (in_cmt_valid && in_cmt_set_nzcv && nzcv_busy_r && (nzcv_tag_r == in_cmt_tag)) begin
                nzcv_val_s = in_cmt_nzcv;
                nzcv_vld_s = 1'b1;
            end else begin
                nzcv_val_s = nzcv_r;
                nzcv_vld_s = ~nzcv_busy_r;
            end
`else
            nzcv_val_s = nzcv_r;
            nzcv_vld_s = ~nzcv_busy_r;
`endif
        end else begin
            nzcv_val_s = 4'b0000;
        end
    end

    // Architectural state: commit writes value, rename overrides busy/tag, flush clears busy
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                gpr_val_r[i] <= '0;
                gpr_tag_r[i] <= '0;
            end
            gpr_busy_r  <= '0;
            nzcv_r      <= 4'b0000;
            nzcv_busy_r <= 1'b0;
            nzcv_tag_r  <= '0;
        end else begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                if (i != XZR_I) begin
                    if (in_cmt_valid && (in_cmt_reg == IDX_W'(i))) begin
                        gpr_val_r[i] <= in_cmt_val;
                        if (gpr_busy_r[i] && (gpr_tag_r[i] == in_cmt_tag))
                            gpr_busy_r[i] <= 1'b0;
                    end
                    if (in_flush) begin
                        gpr_busy_r[i] <= 1'b0;
                    end else if (rename_s && (in_d_dst == IDX_W'(i))) begin
                        gpr_busy_r[i] <= 1'b1;
                        gpr_tag_r[i]  <= in_rob_next_idx;
                    end
                end
            end
            if (in_cmt_valid && in_cmt_set_nzcv) begin
                nzcv_r <= in_cmt_nzcv;
                if (nzcv_busy_r && (nzcv_tag_r == in_cmt_tag))
                    nzcv_busy_r <= 1'b0;
            end
            if (in_flush) begin
                nzcv_busy_r <= 1'b0;
            end else if (accept_s && in_d_set_nzcv) begin
                nzcv_busy_r <= 1'b1;
                nzcv_tag_r  <= in_rob_next_idx;
            end
        end
    end

    // Output packet register; holds while the ROB stalls
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            rob_valid_r    <= 1'b0;
            rob_src_val_r  <= '0;
            rob_src_vld_r  <= '0;
            rob_src_tag_r  <= '0;
            rob_nzcv_r     <= 4'b0000;
            rob_nzcv_vld_r <= 1'b0;
            rob_nzcv_tag_r <= '0;
            rob_dst_r      <= '0;
            rob_dst_en_r   <= 1'b0;
            rob_set_nzcv_r <= 1'b0;
        end else if (in_flush) begin
            rob_valid_r <= 1'b0;
        end else if (d_ready_s) begin
            rob_valid_r <= in_d_valid;
            if (in_d_valid) begin
                for (int i = 0; i < N_SRC; i++) begin
                    rob_src_val_r[i*DATA_W +: DATA_W]       <= src_val_s[i];
                    rob_src_tag_r[i*ROB_IDX_W +: ROB_IDX_W] <= src_tag_s[i];
                end
                rob_src_vld_r  <= src_vld_s;
                rob_nzcv_r     <= nzcv_val_s;
                rob_nzcv_vld_r <= nzcv_vld_s;
                rob_nzcv_tag_r <= nzcv_tag_s;
                rob_dst_r      <= in_d_dst;
                rob_dst_en_r   <= in_d_dst_en;
                rob_set_nzcv_r <= in_d_set_nzcv;
            end
        end
    end

    assign out_d_ready      = d_ready_s;
    assign out_rob_valid    = rob_valid_r;
    assign out_rob_src_val  = rob_src_val_r;
    assign out_rob_src_vld  = rob_src_vld_r;
    assign out_rob_src_tag  = rob_src_tag_r;
    assign out_rob_nzcv     = rob_nzcv_r;
    assign out_rob_nzcv_vld = rob_nzcv_vld_r;
    assign out_rob_nzcv_tag = rob_nzcv_tag_r;
    assign out_rob_dst      = rob_dst_r;
    assign out_rob_dst_en   = rob_dst_en_r;
    assign out_rob_set_nzcv = rob_set_nzcv_r;

endmodule

// File: tb/tb_reg_rename_table.sv
// Scenario bench for reg_rename_table: expected ROB packets queued at drive time, popped on output.
module tb_reg_rename_table;

    localparam logic [1:0] GPR = 2'd0, IMM = 2'd1, PCS = 2'd2, UNU = 2'd3;

    logic         in_clk = 1'b0;
    logic         in_rst_n = 1'b0;
    logic         in_d_valid = 1'b0;
    logic         out_d_ready;
    logic [9:0]   in_d_src = 10'd0;
    logic [3:0]   in_d_src_status = 4'd0;
    logic [63:0]  in_d_imm = 64'd0;
    logic [63:0]  in_d_pc = 64'h1000;
    logic [4:0]   in_d_dst = 5'd0;
    logic         in_d_dst_en = 1'b0;
    logic         in_d_set_nzcv = 1'b0;
    logic         in_d_uses_nzcv = 1'b0;
    logic [3:0]   in_rob_next_idx = 4'd0;
    logic         out_rob_valid;
    logic         in_rob_ready = 1'b1;
    logic [127:0] out_rob_src_val;
    logic [1:0]   out_rob_src_vld;
    logic [7:0]   out_rob_src_tag;
    logic [3:0]   out_rob_nzcv;
    logic         out_rob_nzcv_vld;
    logic [3:0]   out_rob_nzcv_tag;
    logic [4:0]   out_rob_dst;
    logic         out_rob_dst_en;
    logic         out_rob_set_nzcv;
    logic         in_cmt_valid = 1'b0;
    logic [4:0]   in_cmt_reg = 5'd0;
    logic [3:0]   in_cmt_tag = 4'd0;
    logic [63:0]  in_cmt_val = 64'd0;
    logic         in_cmt_set_nzcv = 1'b0;
    logic [3:0]   in_cmt_nzcv = 4'd0;
    logic         in_flush = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [63:0] v0; logic d0; logic [3:0] t0;
        logic [63:0] v1; logic d1; logic [3:0] t1;
        logic [3:0]  nz; logic nzd; logic [3:0] nzt;
        logic [4:0]  dst; logic en; logic set;
    } pkt_t;

    pkt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    reg_rename_table dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_d_valid(in_d_valid), .out_d_ready(out_d_ready),
        .in_d_src(in_d_src), .in_d_src_status(in_d_src_status), .in_d_imm(in_d_imm), .in_d_pc(in_d_pc),
        .in_d_dst(in_d_dst), .in_d_dst_en(in_d_dst_en), .in_d_set_nzcv(in_d_set_nzcv),
        .in_d_uses_nzcv(in_d_uses_nzcv), .in_rob_next_idx(in_rob_next_idx), .out_rob_valid(out_rob_valid),
        .in_rob_ready(in_rob_ready), .out_rob_src_val(out_rob_src_val), .out_rob_src_vld(out_rob_src_vld),
        .out_rob_src_tag(out_rob_src_tag), .out_rob_nzcv(out_rob_nzcv), .out_rob_nzcv_vld(out_rob_nzcv_vld),
        .out_rob_nzcv_tag(out_rob_nzcv_tag), .out_rob_dst(out_rob_dst), .out_rob_dst_en(out_rob_dst_en),
        .out_rob_set_nzcv(out_rob_set_nzcv), .in_cmt_valid(in_cmt_valid), .in_cmt_reg(in_cmt_reg),
        .in_cmt_tag(in_cmt_tag), .in_cmt_val(in_cmt_val), .in_cmt_set_nzcv(in_cmt_set_nzcv),
        .in_cmt_nzcv(in_cmt_nzcv), .in_flush(in_flush)
    );

    always #5 in_clk = ~in_clk;

    function automatic pkt_t mk(input logic [63:0] v0, input logic d0, input logic [3:0] t0,
                                input logic [63:0] v1, input logic d1, input logic [3:0] t1,
                                input logic [3:0] nz, input logic nzd, input logic [3:0] nzt,
                                input logic [4:0] dst, input logic en, input logic set);
        pkt_t p;
        p = '{1'b1, v0, d0, t0, v1, d1, t1, nz, nzd, nzt, dst, en, set};
        return p;
    endfunction

    function automatic pkt_t cap();
        pkt_t p;
        p = '{out_rob_valid, out_rob_src_val[63:0], out_rob_src_vld[0], out_rob_src_tag[3:0],
              out_rob_src_val[127:64], out_rob_src_vld[1], out_rob_src_tag[7:4],
              out_rob_nzcv, out_rob_nzcv_vld, out_rob_nzcv_tag, out_rob_dst, out_rob_dst_en, out_rob_set_nzcv};
        return p;
    endfunction

    // Drive one op for a single edge, queue its expected packet; returns at edge + 1
    task automatic send(input logic [4:0] s0, input logic [1:0] st0, input logic [4:0] s1, input logic [1:0] st1,
                        input logic [63:0] imm, input logic [4:0] dst, input logic en, input logic set_nz,
                        input logic use_nz, input logic [3:0] nxt, input pkt_t e);
        @(negedge in_clk);
        in_d_valid = 1'b1; in_d_src = {s1, s0}; in_d_src_status = {st1, st0}; in_d_imm = imm;
        in_d_dst = dst; in_d_dst_en = en; in_d_set_nzcv = set_nz; in_d_uses_nzcv = use_nz;
        in_rob_next_idx = nxt;
        exp_q.push_back(e);
        @(posedge in_clk); #1;
        in_d_valid = 1'b0; in_cmt_valid = 1'b0; in_cmt_set_nzcv = 1'b0;
    endtask

    task automatic idle();
        @(posedge in_clk); #1;
    endtask

    task automatic test_reset();
        pkt_t got, e;
        in_rst_n = 1'b0;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk); in_rst_n = 1'b1;
        checks++;
        if ({out_rob_valid, out_d_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_state got=%b exp=01", {out_rob_valid, out_d_ready});
        end
        send(5'd3, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL read_x3 got=%h exp=%h", got, e); end
    endtask

    task automatic test_rename();
        pkt_t got, e;
        send(5'd1, GPR, 5'd0, IMM, 64'd5, 5'd1, 1'b1, 1'b1, 1'b0, 4'd7,
             mk(64'd0, 1'b1, 4'd0, 64'd5, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd1, 1'b1, 1'b1));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL add_x1 got=%h exp=%h", got, e); end
        send(5'd1, GPR, 5'd0, PCS, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd8,
             mk(64'd0, 1'b0, 4'd7, 64'h1000, 1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL read_renamed got=%h exp=%h", got, e); end
    endtask

    task automatic test_commit();
        pkt_t got, e;
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd1; in_cmt_tag = 4'd7; in_cmt_val = 64'd42;
        in_cmt_set_nzcv = 1'b1; in_cmt_nzcv = 4'b1010;
`ifdef RRT_COMMIT_BYPASS_EN
        e = mk(64'd42, 1'b1, 4'd7, 64'd0, 1'b1, 4'd0, 4'b1010, 1'b1, 4'd7, 5'd0, 1'b0, 1'b0);
`else
        e = mk(64'd0, 1'b0, 4'd7, 64'd0, 1'b1, 4'd0, 4'b0000, 1'b0, 4'd7, 5'd0, 1'b0, 1'b0);
`endif
        send(5'd1, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd8, e);
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL commit_same_cycle got=%h exp=%h", got, e); end
        send(5'd1, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd8,
             mk(64'd42, 1'b1, 4'd7, 64'd0, 1'b1, 4'd0, 4'b1010, 1'b1, 4'd7, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL after_commit got=%h exp=%h", got, e); end
    endtask

    task automatic test_stale_commit();
        pkt_t got, e;
        send(5'd0, UNU, 5'd0, UNU, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0, 4'd9,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd1, 1'b1, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rename_x1_9 got=%h exp=%h", got, e); end
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd1; in_cmt_tag = 4'd3; in_cmt_val = 64'd77;
        idle();
        in_cmt_valid = 1'b0;
        send(5'd1, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0,
             mk(64'd77, 1'b0, 4'd9, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL stale_commit got=%h exp=%h", got, e); end
    endtask

    task automatic test_backpressure();
        pkt_t got, e, held;
        idle();
        in_rob_ready = 1'b0;
        held = mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd5, 1'b1, 1'b0);
        send(5'd5, GPR, 5'd0, UNU, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 4'd10, held);
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL bp_first got=%h exp=%h", got, e); end
        in_d_valid = 1'b1; in_d_src = {5'd0, 5'd5}; in_d_src_status = {UNU, GPR};
        in_d_dst = 5'd6; in_d_dst_en = 1'b1; in_d_uses_nzcv = 1'b0; in_rob_next_idx = 4'd11;
        for (int c = 0; c < 3; c++) begin
            @(posedge in_clk); #1;
            got = cap(); checks++;
            if ({got, out_d_ready} !== {held, 1'b0}) begin
                errors++; $display("FAIL bp_hold%0d got=%h/%b exp=%h/0", c, got, out_d_ready, held);
            end
        end
        in_rob_ready = 1'b1;
        exp_q.push_back(mk(64'd0, 1'b0, 4'd10, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd6, 1'b1, 1'b0));
        @(posedge in_clk); #1;
        in_d_valid = 1'b0;
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL bp_release got=%h exp=%h", got, e); end
    endtask

    task automatic test_flush();
        pkt_t got, e;
        send(5'd0, UNU, 5'd0, UNU, 64'd0, 5'd2, 1'b1, 1'b0, 1'b0, 4'd12,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd2, 1'b1, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rename_x2 got=%h exp=%h", got, e); end
        in_flush = 1'b1; in_d_valid = 1'b1; in_d_src = {5'd0, 5'd2}; in_d_src_status = {UNU, GPR};
        in_d_dst = 5'd4; in_d_dst_en = 1'b1; in_rob_next_idx = 4'd13;
        @(posedge in_clk); #1;
        in_flush = 1'b0; in_d_valid = 1'b0;
        checks++;
        if (out_rob_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_rob_valid); end
        send(5'd2, GPR, 5'd4, GPR, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0,
             mk(64'd0, 1'b1, 4'd12, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL after_flush got=%h exp=%h", got, e); end
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd31; in_cmt_tag = 4'd0; in_cmt_val = 64'd99;
        send(5'd31, GPR, 5'd31, GPR, 64'd0, 5'd31, 1'b1, 1'b0, 1'b0, 4'd14,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd31, 1'b1, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL xzr_write got=%h exp=%h", got, e); end
        send(5'd31, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL xzr_read got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid();
        pkt_t got, e;
        idle();
        in_rob_ready = 1'b0;
        send(5'd1, GPR, 5'd0, UNU, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0, 4'd15,
             mk(64'd77, 1'b1, 4'd9, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd1, 1'b1, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL pre_reset got=%h exp=%h", got, e); end
        in_rst_n = 1'b0;
        @(posedge in_clk); #1;
        checks++;
        if ({out_rob_valid, out_d_ready} !== 2'b01) begin
            errors++; $display("FAIL mid_reset got=%b exp=01", {out_rob_valid, out_d_ready});
        end
        in_rst_n = 1'b1; in_rob_ready = 1'b1;
        send(5'd1, GPR, 5'd0, UNU, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0,
             mk(64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0));
        got = cap(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_rename();
        test_commit();
        test_stale_commit();
        test_backpressure();
        test_flush();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
